hub75_linebuffer_ring: RTL and testbench

Multi-line ring of HUB75 line buffers. The framebuffer-side writer fills a "back" line while the shifter-side reader scans a "front" line. Ownership of each line passes through a commit/release handshake, so the writer never overwrites a line still being shifted out. It replaces single-line buffering between the frame reader and the hub75 shift engine.

---
 rtl/hub75_linebuffer_ring_pkg.sv | 24 ++
 rtl/hub75_linebuffer_ring_if.sv | 39 +++
 rtl/hub75_lb_ram.sv | 36 +++
 rtl/hub75_linebuffer_ring.sv | 112 +++++++++++
 tb/tb_hub75_linebuffer_ring.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_linebuffer_ring_pkg.sv
// Shared hub75 line-buffer definitions: line-index width helpers and the
// read latency seen by the shifter.
// Build option: HUB75_LB_RDREG_EN adds an output register on the read path.
package hub75_linebuffer_ring_pkg;

`ifdef HUB75_LB_RDREG_EN
  // Registered RAM read plus one output stage.
  localparam int RD_LATENCY = 2;
`else
  // Registered RAM read only.
  localparam int RD_LATENCY = 1;
`endif

  // Number of line slots in a ring indexed by line_bits bits.
  function automatic int n_lines(input int line_bits);
    return 1 << line_bits;
  endfunction

  // Line-index width for a ring of n slots; never narrower than one bit.
  function automatic int line_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hub75_linebuffer_ring_if.sv
// Writer/reader bus of the hub75 line-buffer ring.
//
// Handshake: wr_ready says a free line exists; wr_ena/wr_commit are acted on
// only in cycles where wr_ready=1 and are silently dropped otherwise.
// rd_ready says a committed line exists; rd_release is acted on only while
// rd_ready=1. rd_valid marks rd_data as coming from a read issued while
// rd_ready=1. There is no back-pressure beyond these ready levels.
interface hub75_linebuffer_ring_if #(
  parameter int N_WORDS    = 1,
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 6
) ();
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [N_WORDS*WORD_WIDTH-1:0] wr_data;
  logic [N_WORDS-1:0]            wr_mask;
  logic                          wr_ena;
  logic                          wr_commit;
  logic                          wr_ready;
  logic [ADDR_WIDTH-1:0]         rd_addr;
  logic                          rd_ena;
  logic [N_WORDS*WORD_WIDTH-1:0] rd_data;
  logic                          rd_valid;
  logic                          rd_release;
  logic                          rd_ready;

  // Frame reader / shift engine side.
  modport master (
    output wr_addr, wr_data, wr_mask, wr_ena, wr_commit,
    output rd_addr, rd_ena, rd_release,
    input  wr_ready, rd_data, rd_valid, rd_ready
  );

  // Ring side.
  modport slave (
    input  wr_addr, wr_data, wr_mask, wr_ena, wr_commit,
    input  rd_addr, rd_ena, rd_release,
    output wr_ready, rd_data, rd_valid, rd_ready
  );
endinterface

// File: rtl/hub75_lb_ram.sv
// Simple dual-port RAM with per-word masked write and registered read.
// No reset on storage or read register so it maps onto block RAM.
module hub75_lb_ram #(
  parameter int N_WORDS    = 1,
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [N_WORDS-1:0]            wmask,
  input  logic [N_WORDS*WORD_WIDTH-1:0] wdata,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         raddr,
  output logic [N_WORDS*WORD_WIDTH-1:0] rdata
);

  logic [N_WORDS*WORD_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Masked write: only enabled words of the entry are updated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_WORDS; i++) begin
      if (we && wmask[i]) begin
        mem[waddr][i*WORD_WIDTH +: WORD_WIDTH] <= wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Registered read; holds the last value when no read is issued.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hub75_linebuffer_ring.sv
// Ring of HUB75 line buffers passing whole lines from the frame-buffer
// writer to the shift-engine reader through commit/release handshakes.
// Build option: HUB75_LB_RDREG_EN adds a reset output stage on rd_data/rd_valid.
module hub75_linebuffer_ring
  import hub75_linebuffer_ring_pkg::*;
#(
  parameter int N_WORDS    = 1,
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 6,
  parameter int LINE_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  hub75_linebuffer_ring_if.slave bus
);

  localparam int N_LINES = n_lines(LINE_BITS);
  localparam int DW      = N_WORDS * WORD_WIDTH;
  localparam logic [LINE_BITS:0] LEVEL_FULL = (LINE_BITS+1)'(N_LINES);

  logic [LINE_BITS-1:0] wr_ptr;
  logic [LINE_BITS-1:0] rd_ptr;
  logic [LINE_BITS:0]   level;
  logic                 wr_ready;
  logic                 rd_ready;
  logic                 wr_take;
  logic                 commit_take;
  logic                 release_take;
  logic                 rd_valid_s1;
  logic [DW-1:0]        ram_rdata;

  // Free line exists unless every slot is committed; a committed line
  // exists whenever the level is non-zero. Writer and reader never share a
  // slot while both are ready, so no read/write arbitration is needed.
  assign wr_ready     = (level != LEVEL_FULL);
  assign rd_ready     = (level != '0);
  assign wr_take      = bus.wr_ena     && wr_ready;
  assign commit_take  = bus.wr_commit  && wr_ready;
  assign release_take = bus.rd_release && rd_ready;

  // Pointer and occupancy update; simultaneous commit+release leaves level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (commit_take) begin
        wr_ptr <= wr_ptr + LINE_BITS'(1);
      end
      if (release_take) begin
        rd_ptr <= rd_ptr + LINE_BITS'(1);
      end
      case ({commit_take, release_take})
        2'b10:   level <= level + (LINE_BITS+1)'(1);
        2'b01:   level <= level - (LINE_BITS+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Read-valid tracks the RAM read register: set only for reads of a committed line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_s1 <= 1'b0;
    end else begin
      rd_valid_s1 <= bus.rd_ena && rd_ready;
    end
  end

  // Old pointers are used for a write/read in the same cycle as its commit/release.
  hub75_lb_ram #(
    .N_WORDS    (N_WORDS),
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (LINE_BITS + ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_take),
    .waddr ({wr_ptr, bus.wr_addr}),
    .wmask (bus.wr_mask),
    .wdata (bus.wr_data),
    .re    (bus.rd_ena),
    .raddr ({rd_ptr, bus.rd_addr}),
    .rdata (ram_rdata)
  );

`ifdef HUB75_LB_RDREG_EN
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;

  // Output stage for timing; reset to zero so rd_data is defined after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= ram_rdata;
      rd_valid_q <= rd_valid_s1;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`else
  assign bus.rd_data  = ram_rdata;
  assign bus.rd_valid = rd_valid_s1;
`endif

  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;

endmodule

// File: tb/tb_hub75_linebuffer_ring.sv
// Bench for hub75_linebuffer_ring: a default ping-pong instance driven from a
// vector table, and a 2x8-bit, 4-line instance driven by hand sequences.
module tb_hub75_linebuffer_ring;

`ifdef HUB75_LB_RDREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hub75_linebuffer_ring_if #(.N_WORDS(1), .WORD_WIDTH(24), .ADDR_WIDTH(6)) bus_a ();
  hub75_linebuffer_ring_if #(.N_WORDS(2), .WORD_WIDTH(8),  .ADDR_WIDTH(3)) bus_b ();

  hub75_linebuffer_ring #(
    .N_WORDS(1), .WORD_WIDTH(24), .ADDR_WIDTH(6), .LINE_BITS(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  hub75_linebuffer_ring #(
    .N_WORDS(2), .WORD_WIDTH(8), .ADDR_WIDTH(3), .LINE_BITS(2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table for dut_a ----------------
  typedef struct packed {
    logic        we;
    logic [5:0]  wa;
    logic [23:0] wd;
    logic        wc;
    logic        re;
    logic [5:0]  ra;
    logic        rr;
    logic        exp_wr_ready;
    logic        exp_rd_ready;
    logic        chk;
    logic [23:0] exp_data;
  } vec_t;

  localparam int N_VEC = 26;
  vec_t tbl [N_VEC];

  // Scoreboard entries: {expected rd_valid, check data, expected rd_data}.
  logic [25:0] exp_q [$];

  function automatic vec_t mk(input logic we, input logic [5:0] wa, input logic [23:0] wd,
                              input logic wc, input logic re, input logic [5:0] ra,
                              input logic rr, input logic ewr, input logic erd,
                              input logic chk, input logic [23:0] ed);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.wc = wc;
    v.re = re; v.ra = ra; v.rr = rr;
    v.exp_wr_ready = ewr; v.exp_rd_ready = erd;
    v.chk = chk; v.exp_data = ed;
    return v;
  endfunction

  task automatic fill_table();
    //             we wa  wd          wc re ra  rr ewr erd chk data
    tbl[0]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 0, 0, 24'h0);
    tbl[1]  = mk(0, 0, 24'h0,      0, 1, 5, 0, 1, 0, 0, 24'h0);      // read with nothing committed
    tbl[2]  = mk(1, 5, 24'hA1B2C3, 0, 0, 0, 0, 1, 0, 0, 24'h0);
    tbl[3]  = mk(0, 0, 24'h0,      1, 0, 0, 0, 1, 0, 0, 24'h0);      // commit line 0
    tbl[4]  = mk(0, 0, 24'h0,      0, 1, 5, 0, 1, 1, 1, 24'hA1B2C3);
    tbl[5]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 1, 24'hA1B2C3); // data holds, valid drops
    tbl[6]  = mk(1, 5, 24'h445566, 1, 0, 0, 0, 1, 1, 0, 24'h0);      // write+commit line 1
    tbl[7]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 0, 1, 0, 24'h0);      // full
    tbl[8]  = mk(1, 5, 24'hFFFFFF, 1, 0, 0, 0, 0, 1, 0, 24'h0);      // dropped write and commit
    tbl[9]  = mk(0, 0, 24'h0,      0, 1, 5, 0, 0, 1, 1, 24'hA1B2C3);
    tbl[10] = mk(0, 0, 24'h0,      0, 0, 0, 0, 0, 1, 0, 24'h0);
    tbl[11] = mk(0, 0, 24'h0,      0, 1, 5, 1, 0, 1, 1, 24'hA1B2C3); // read+release uses old rd_ptr
    tbl[12] = mk(0, 0, 24'h0,      0, 1, 5, 0, 1, 1, 1, 24'h445566);
    tbl[13] = mk(1, 7, 24'h0A0B0C, 1, 0, 0, 1, 1, 1, 0, 24'h0);      // commit+release at level 1
    tbl[14] = mk(0, 0, 24'h0,      0, 1, 7, 0, 1, 1, 1, 24'h0A0B0C);
    tbl[15] = mk(1, 7, 24'h777777, 0, 0, 0, 0, 1, 1, 0, 24'h0);      // writer now on line 1
    tbl[16] = mk(0, 0, 24'h0,      0, 1, 7, 0, 1, 1, 1, 24'h0A0B0C);
    tbl[17] = mk(0, 0, 24'h0,      0, 0, 0, 1, 1, 1, 0, 24'h0);
    tbl[18] = mk(0, 0, 24'h0,      0, 1, 7, 0, 1, 0, 0, 24'h0);      // empty: read not valid
    tbl[19] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 0, 0, 24'h0);
    tbl[20] = mk(0, 0, 24'h0,      0, 0, 0, 1, 1, 0, 0, 24'h0);      // release while empty ignored
    tbl[21] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 0, 0, 24'h0);
    tbl[22] = mk(0, 0, 24'h0,      1, 0, 0, 0, 1, 0, 0, 24'h0);      // commit line 1
    tbl[23] = mk(0, 0, 24'h0,      0, 1, 7, 0, 1, 1, 1, 24'h777777);
    tbl[24] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 0, 24'h0);
    tbl[25] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 0, 24'h0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_a();
    bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_mask = 1'b1;
    bus_a.wr_ena = 1'b0; bus_a.wr_commit = 1'b0;
    bus_a.rd_addr = '0; bus_a.rd_ena = 1'b0; bus_a.rd_release = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_mask = 2'b00;
    bus_b.wr_ena = 1'b0; bus_b.wr_commit = 1'b0;
    bus_b.rd_addr = '0; bus_b.rd_ena = 1'b0; bus_b.rd_release = 1'b0;
  endtask

  // One clock of dut_b activity; returns #1 after the edge with inputs idle.
  task automatic b_step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [1:0] wm, input logic wc, input logic re,
                        input logic [2:0] ra, input logic rr);
    @(negedge clk);
    bus_b.wr_ena = we; bus_b.wr_addr = wa; bus_b.wr_data = wd; bus_b.wr_mask = wm;
    bus_b.wr_commit = wc; bus_b.rd_ena = re; bus_b.rd_addr = ra; bus_b.rd_release = rr;
    @(posedge clk);
    #1;
    idle_b();
  endtask

  task automatic b_read(input logic [2:0] ra, input logic [15:0] exp, input string name);
    b_step(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b1, ra, 1'b0);
    repeat (RD_LAT - 1) begin
      @(posedge clk);
      #1;
    end
    check({name, " rd_valid"}, 64'(bus_b.rd_valid), 64'd1);
    check({name, " rd_data"},  64'(bus_b.rd_data),  64'(exp));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [25:0] e;
    checks = 0;
    errors = 0;
    idle_a();
    idle_b();
    rst = 1'b1;
    fill_table();
    repeat (3) @(posedge clk);
    #1;
    check("reset wr_ready a", 64'(bus_a.wr_ready), 64'd1);
    check("reset rd_ready a", 64'(bus_a.rd_ready), 64'd0);
    check("reset rd_valid a", 64'(bus_a.rd_valid), 64'd0);
    check("reset wr_ready b", 64'(bus_b.wr_ready), 64'd1);
    check("reset rd_ready b", 64'(bus_b.rd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table run on dut_a. Outputs are checked at the falling edge before the
    // row's inputs take effect; read results come out RD_LAT rows later.
    for (int i = 0; i < RD_LAT; i++) exp_q.push_back('0);
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      check($sformatf("row%0d wr_ready", i), 64'(bus_a.wr_ready), 64'(tbl[i].exp_wr_ready));
      check($sformatf("row%0d rd_ready", i), 64'(bus_a.rd_ready), 64'(tbl[i].exp_rd_ready));
      e = exp_q.pop_front();
      check($sformatf("row%0d rd_valid", i), 64'(bus_a.rd_valid), 64'(e[25]));
      if (e[24]) check($sformatf("row%0d rd_data", i), 64'(bus_a.rd_data), 64'(e[23:0]));
      exp_q.push_back({tbl[i].re & tbl[i].exp_rd_ready, tbl[i].chk, tbl[i].exp_data});
      bus_a.wr_ena = tbl[i].we;  bus_a.wr_addr = tbl[i].wa; bus_a.wr_data = tbl[i].wd;
      bus_a.wr_commit = tbl[i].wc; bus_a.rd_ena = tbl[i].re; bus_a.rd_addr = tbl[i].ra;
      bus_a.rd_release = tbl[i].rr;
    end
    @(negedge clk);
    idle_a();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("drain rd_valid", 64'(bus_a.rd_valid), 64'(e[25]));
      @(negedge clk);
    end

    // dut_b: masked write; second write lands in the line it commits.
    b_step(1'b1, 3'd2, 16'h1122, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0);
    b_step(1'b1, 3'd2, 16'h33FF, 2'b10, 1'b1, 1'b0, 3'd0, 1'b0);
    check("b rd_ready after commit", 64'(bus_b.rd_ready), 64'd1);
    b_read(3'd2, 16'h3322, "b mask");

    // Fill remaining three lines.
    for (int k = 1; k < 4; k++) begin
      b_step(1'b1, 3'd0, 16'hA000 + 16'(k), 2'b11, 1'b1, 1'b0, 3'd0, 1'b0);
    end
    check("b full wr_ready", 64'(bus_b.wr_ready), 64'd0);
    check("b full rd_ready", 64'(bus_b.rd_ready), 64'd1);
    // Dropped write would land on line 0 addr 2 if not gated; dropped commit.
    b_step(1'b1, 3'd2, 16'hFFFF, 2'b11, 1'b1, 1'b0, 3'd0, 1'b0);
    check("b full ignore wr_ready", 64'(bus_b.wr_ready), 64'd0);

    // Drain in commit order.
    b_read(3'd2, 16'h3322, "b line0");
    b_step(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1);
    check("b rel0 wr_ready", 64'(bus_b.wr_ready), 64'd1);
    for (int k = 1; k < 4; k++) begin
      b_read(3'd0, 16'hA000 + 16'(k), $sformatf("b line%0d", k));
      b_step(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1);
    end
    check("b empty rd_ready", 64'(bus_b.rd_ready), 64'd0);
    check("b empty wr_ready", 64'(bus_b.wr_ready), 64'd1);

    // Both pointers wrapped to line 0.
    b_step(1'b1, 3'd0, 16'h5A5A, 2'b11, 1'b1, 1'b0, 3'd0, 1'b0);
    b_read(3'd0, 16'h5A5A, "b wrap");

    // Mid-line async reset while rd_valid is high.
    rst = 1'b1;
    #1;
    check("b midrst rd_valid", 64'(bus_b.rd_valid), 64'd0);
    check("b midrst rd_ready", 64'(bus_b.rd_ready), 64'd0);
    check("b midrst wr_ready", 64'(bus_b.wr_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("b post rst rd_ready", 64'(bus_b.rd_ready), 64'd0);

    // Final report.
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
